sync_fifo_prog: RTL and testbench

//  Parametrised single-clock FIFO with programmable full/empty thresholds and an occupancy count.

---
 rtl/sync_fifo_prog.sv | 128 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
//------------------------------------------------------------------------------
// sync_fifo_prog : single-clock FIFO, programmable thresholds, std/FWFT read
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_prog #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int PROG_FULL_TH  = 12,
  parameter int PROG_EMPTY_TH = 2,
  parameter int FWFT          = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       prog_full,
  output logic                       overflow,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       empty,
  output logic                       prog_empty,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of 2 and >= 4");
  end
  if ((PROG_EMPTY_TH < 0) || (PROG_EMPTY_TH >= PROG_FULL_TH) || (PROG_FULL_TH > DEPTH)) begin : g_bad_th
    $error("sync_fifo_prog: need 0 <= PROG_EMPTY_TH < PROG_FULL_TH <= DEPTH");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, prog_full_q, prog_empty_q;
  logic             overflow_q, underflow_q;
  logic             w_wr_acc, w_rd_acc;

  // Acceptance uses only registered flags: no write-through when full, no read-through when empty.
  assign w_wr_acc = wr_en && !full_q;
  assign w_rd_acc = rd_en && !empty_q;

  always_comb begin
    count_d = count_q;
    if (w_wr_acc && !w_rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_rd_acc) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q      <= count_d;
      full_q       <= (count_d == CW'(DEPTH));
      empty_q      <= (count_d == '0);
      prog_full_q  <= (count_d >= CW'(PROG_FULL_TH));
      prog_empty_q <= (count_d <= CW'(PROG_EMPTY_TH));
      overflow_q   <= wr_en && full_q;
      underflow_q  <= rd_en && empty_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented straight from the array; gated to zero while empty.
    assign valid = !empty_q;
    assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= w_rd_acc;
        if (w_rd_acc) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end
    end

    assign valid = valid_q;
    assign dout  = dout_q;
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign prog_full  = prog_full_q;
  assign prog_empty = prog_empty_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign data_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
//------------------------------------------------------------------------------
// tb_sync_fifo_prog : checks std and FWFT instances against a queue-based model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_prog;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int PFT   = 12;
  localparam int PET   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] din = '0;

  logic             s_full, s_pfull, s_of, s_valid, s_empty, s_pempty, s_uf;
  logic [WIDTH-1:0] s_dout;
  logic [4:0]       s_cnt;
  logic             f_full, f_pfull, f_of, f_valid, f_empty, f_pempty, f_uf;
  logic [WIDTH-1:0] f_dout;
  logic [4:0]       f_cnt;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PROG_FULL_TH(PFT), .PROG_EMPTY_TH(PET), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(s_full), .prog_full(s_pfull),
    .overflow(s_of), .rd_en(rd_en), .dout(s_dout), .valid(s_valid), .empty(s_empty),
    .prog_empty(s_pempty), .underflow(s_uf), .data_count(s_cnt)
  );

  sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PROG_FULL_TH(PFT), .PROG_EMPTY_TH(PET), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(f_full), .prog_full(f_pfull),
    .overflow(f_of), .rd_en(rd_en), .dout(f_dout), .valid(f_valid), .empty(f_empty),
    .prog_empty(f_pempty), .underflow(f_uf), .data_count(f_cnt)
  );

  // Reference model: a queue of stored words plus the std-mode output register.
  logic [WIDTH-1:0] q [$];
  logic             m_of, m_uf, m_v0;
  logic [WIDTH-1:0] m_d0;
  int               n_cmp = 0;
  int               n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int c;
    c = q.size();
    chk("std.count",  32'(s_cnt),    32'(c));
    chk("fwft.count", 32'(f_cnt),    32'(c));
    chk("std.full",   32'(s_full),   32'(c == DEPTH));
    chk("fwft.full",  32'(f_full),   32'(c == DEPTH));
    chk("std.empty",  32'(s_empty),  32'(c == 0));
    chk("fwft.empty", 32'(f_empty),  32'(c == 0));
    chk("std.pfull",  32'(s_pfull),  32'(c >= PFT));
    chk("fwft.pfull", 32'(f_pfull),  32'(c >= PFT));
    chk("std.pempty", 32'(s_pempty), 32'(c <= PET));
    chk("fwft.pempty",32'(f_pempty), 32'(c <= PET));
    chk("std.ovf",    32'(s_of),     32'(m_of));
    chk("fwft.ovf",   32'(f_of),     32'(m_of));
    chk("std.unf",    32'(s_uf),     32'(m_uf));
    chk("fwft.unf",   32'(f_uf),     32'(m_uf));
    chk("std.valid",  32'(s_valid),  32'(m_v0));
    chk("std.dout",   32'(s_dout),   32'(m_d0));
    chk("fwft.valid", 32'(f_valid),  32'(c != 0));
    if (c != 0) chk("fwft.head", 32'(f_dout), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
    logic was_full, was_empty;
    wr_en = w; din = d; rd_en = r;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_of = w && was_full;
    m_uf = r && was_empty;
    m_v0 = r && !was_empty;
    if (r && !was_empty) m_d0 = q.pop_front();
    if (w && !was_full) q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      wr_en = 1'b1; din = WIDTH'($urandom); rd_en = 1'(i & 1);
      @(posedge clk);
      q.delete();
      m_of = 1'b0; m_uf = 1'b0; m_v0 = 1'b0; m_d0 = '0;
      #1;
      check_all();
      chk("fwft.rst_dout", 32'(f_dout), 32'd0);
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    m_of = 1'b0; m_uf = 1'b0; m_v0 = 1'b0; m_d0 = '0;
    #2;
    do_reset(2);

    // Reset while holding data.
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h30 + i), 1'b0);
    do_reset(10);

    // Fill to full, then an overflowing write that must be dropped.
    for (int i = 0; i < 16; i++) step(1'b1, WIDTH'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Drain everything, then underflow.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("std.dout_hold", 32'(s_dout), 32'h0F);

    // Steady state at count 8 with simultaneous read and write.
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, WIDTH'($urandom), 1'b1);
    while (q.size() < DEPTH) step(1'b1, WIDTH'($urandom), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("full_rdwr_count", 32'(s_cnt), 32'd15);
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Pointer wrap through repeated fill/drain rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(r * 16 + i), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0);

    // FWFT fall-through of a single word.
    step(1'b1, 8'h5A, 1'b0);
    chk("fwft.fall_through", 32'(f_dout), 32'h5A);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft.pop_valid", 32'(f_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0);

    // Randomised traffic with drifting write/read bias.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 100) % 2 == 0) ? 70 : 30;
      step(1'($urandom_range(99) < bias), WIDTH'($urandom), 1'($urandom_range(99) >= bias - 10));
    end
    do_reset(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
